l3_glb_read_scheduler: RTL and testbench

- Shares the single GLB read port among NUM_FIFO per-row ifmap/ipsum FIFOs.
- L2C loop controllers post per-FIFO pop requests as a need_pop bit plus a pop count. This block keeps a remaining-count per FIFO and grants the port round-robin to FIFOs that still owe pops and can accept data.
- It reports the per-FIFO done matrix that the L2C WAIT_DONE states AND-reduce.

---
 rtl/l3_glb_read_scheduler.sv | 116 +++++++++++
 tb/tb_l3_glb_read_scheduler.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/l3_glb_read_scheduler.sv
// GLB read-port scheduler: per-FIFO pop counters with round-robin arbitration
// over a single valid/ready read port, plus per-FIFO done reporting.
module l3_glb_read_scheduler #(
    parameter int unsigned NUM_FIFO = 32,
    parameter int unsigned CNT_W    = 32,
    parameter int unsigned ID_W     = $clog2(NUM_FIFO)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_FIFO-1:0] need_pop_matrix_i,
    input  logic [CNT_W-1:0]    pop_num_matrix_i [NUM_FIFO],
    input  logic [NUM_FIFO-1:0] fifo_ready_matrix_i,
    output logic                glb_rd_req_o,
    output logic [ID_W-1:0]     glb_rd_id_o,
    input  logic                glb_rd_gnt_i,
    output logic [NUM_FIFO-1:0] fifo_done_matrix_o,
    output logic                all_done_o,
    output logic                busy_o
);

    typedef enum logic {StArb, StReq} state_e;

    state_e              state;
    logic [CNT_W-1:0]    rem [NUM_FIFO];
    logic [NUM_FIFO-1:0] done;
    logic [NUM_FIFO-1:0] elig;
    logic [ID_W-1:0]     ptr;
    logic [ID_W-1:0]     cur_id;
    logic [ID_W-1:0]     pick_id;
    logic                pick_vld;
    logic                req;

    always_comb begin
        elig = '0;
        for (int k = 0; k < NUM_FIFO; k++) begin
            elig[k] = (rem[k] != '0) && fifo_ready_matrix_i[k];
        end
    end

    // First eligible index at or above ptr, wrapping modulo NUM_FIFO.
    always_comb begin
        logic [31:0]     j;
        logic [ID_W-1:0] idx;
        pick_vld = 1'b0;
        pick_id  = '0;
        j        = '0;
        idx      = '0;
        for (int unsigned i = 0; i < NUM_FIFO; i++) begin
            j   = (32'(ptr) + i) % NUM_FIFO;
            idx = ID_W'(j);
            if (!pick_vld && elig[idx]) begin
                pick_vld = 1'b1;
                pick_id  = idx;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= StArb;
            req    <= 1'b0;
            cur_id <= '0;
            ptr    <= '0;
        end else begin
            unique case (state)
                StArb: begin
                    if (pick_vld) begin
                        cur_id <= pick_id;
                        req    <= 1'b1;
                        state  <= StReq;
                    end
                end
                StReq: begin
                    if (glb_rd_gnt_i) begin
                        req   <= 1'b0;
                        state <= StArb;
                        ptr   <= (cur_id == ID_W'(NUM_FIFO - 1)) ? '0 : cur_id + 1'b1;
                    end
                end
                default: state <= StArb;
            endcase
        end
    end

    // A load beats a same-cycle grant; a count reloaded to zero is never decremented.
    always_ff @(posedge clk) begin
        for (int k = 0; k < NUM_FIFO; k++) begin
            if (rst) begin
                rem[k]  <= '0;
                done[k] <= 1'b0;
            end else if (need_pop_matrix_i[k]) begin
                rem[k]  <= pop_num_matrix_i[k];
                done[k] <= (pop_num_matrix_i[k] == '0);
            end else if (state == StReq && glb_rd_gnt_i && cur_id == ID_W'(k)
                         && rem[k] != '0) begin
                rem[k] <= rem[k] - 1'b1;
                if (rem[k] == CNT_W'(1)) begin
                    done[k] <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        busy_o = 1'b0;
        for (int k = 0; k < NUM_FIFO; k++) begin
            busy_o = busy_o | (rem[k] != '0);
        end
    end

    assign glb_rd_req_o       = req;
    assign glb_rd_id_o        = cur_id;
    assign fifo_done_matrix_o = done;
    assign all_done_o         = &done;

endmodule

// File: tb/tb_l3_glb_read_scheduler.sv
// Bench for l3_glb_read_scheduler: directed scenarios plus random traffic, all
// compared each cycle against a count/queue-level reference model.
module tb_l3_glb_read_scheduler;

    localparam int N = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic [N-1:0]  need;
    logic [31:0]   pop [N];
    logic [N-1:0]  ready;
    logic          req;
    logic [4:0]    id;
    logic          gnt;
    logic [N-1:0]  done;
    logic          all_done;
    logic          busy;

    always #5 clk = ~clk;

    l3_glb_read_scheduler #(.NUM_FIFO(N), .CNT_W(32), .ID_W(5)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .need_pop_matrix_i   (need),
        .pop_num_matrix_i    (pop),
        .fifo_ready_matrix_i (ready),
        .glb_rd_req_o        (req),
        .glb_rd_id_o         (id),
        .glb_rd_gnt_i        (gnt),
        .fifo_done_matrix_o  (done),
        .all_done_o          (all_done),
        .busy_o              (busy)
    );

    // Reference model: owed pops per FIFO, done flags, and the one outstanding request.
    int unsigned m_rem  [N];
    bit          m_done [N];
    bit          m_req;
    int          m_cur;
    int          m_ptr;

    int errors = 0;
    int checks = 0;
    int gq[$];

    task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        int unsigned n_rem  [N];
        bit          n_done [N];
        bit          n_req;
        int          n_cur;
        int          n_ptr;
        logic [N-1:0] exp_done;
        bit          exp_all;
        bit          exp_busy;
        n_rem  = m_rem;
        n_done = m_done;
        n_req  = m_req;
        n_cur  = m_cur;
        n_ptr  = m_ptr;
        if (req === 1'b1 && gnt === 1'b1) gq.push_back(int'(id));
        if (m_req) begin
            if (gnt) begin
                if (m_rem[m_cur] != 0) begin
                    n_rem[m_cur] = m_rem[m_cur] - 1;
                    if (m_rem[m_cur] == 1) n_done[m_cur] = 1'b1;
                end
                n_req = 1'b0;
                n_ptr = (m_cur + 1) % N;
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                int j;
                j = (m_ptr + i) % N;
                if (!n_req && m_rem[j] != 0 && ready[j]) begin
                    n_req = 1'b1;
                    n_cur = j;
                end
            end
        end
        for (int k = 0; k < N; k++) begin
            if (need[k]) begin
                n_rem[k]  = pop[k];
                n_done[k] = (pop[k] == 0);
            end
        end
        if (rst) begin
            for (int k = 0; k < N; k++) begin
                n_rem[k]  = 0;
                n_done[k] = 1'b0;
            end
            n_req = 1'b0;
            n_cur = 0;
            n_ptr = 0;
        end
        @(posedge clk);
        #1;
        m_rem  = n_rem;
        m_done = n_done;
        m_req  = n_req;
        m_cur  = n_cur;
        m_ptr  = n_ptr;
        need   = '0;
        exp_all  = 1'b1;
        exp_busy = 1'b0;
        for (int k = 0; k < N; k++) begin
            exp_done[k] = m_done[k];
            exp_all     = exp_all & m_done[k];
            exp_busy    = exp_busy | (m_rem[k] != 0);
        end
        check("req", 64'(req), 64'(m_req));
        check("id", 64'(id), 64'(m_cur));
        check("done_matrix", 64'(done), 64'(exp_done));
        check("all_done", 64'(all_done), 64'(exp_all));
        check("busy", 64'(busy), 64'(exp_busy));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        int cnt;
        rst   = 1'b1;
        need  = '0;
        ready = '1;
        gnt   = 1'b0;
        for (int k = 0; k < N; k++) pop[k] = 32'd0;
        for (int k = 0; k < N; k++) begin
            m_rem[k]  = 0;
            m_done[k] = 1'b0;
        end
        m_req = 1'b0;
        m_cur = 0;
        m_ptr = 0;

        // Reset held two cycles while need pulses are active.
        for (int c = 0; c < 2; c++) begin
            need = 32'h0000_00ff;
            for (int k = 0; k < 8; k++) pop[k] = 32'd5;
            tick();
        end
        check("reset_req", 64'(req), 64'd0);
        check("reset_done", 64'(done), 64'd0);
        check("reset_busy", 64'(busy), 64'd0);
        rst = 1'b0;
        gnt = 1'b1;
        for (int c = 0; c < 3; c++) tick();
        check("idle_after_reset", 64'(req), 64'd0);

        // Single FIFO, two pops.
        gq.delete();
        need[3] = 1'b1;
        pop[3]  = 32'd2;
        tick();
        check("single_no_req_yet", 64'(req), 64'd0);
        tick();
        check("single_req_latency", 64'(req), 64'd1);
        for (int c = 0; c < 6; c++) tick();
        check("single_grants", 64'(gq.size()), 64'd2);
        if (gq.size() == 2) begin
            check("single_id0", 64'(gq[0]), 64'd3);
            check("single_id1", 64'(gq[1]), 64'd3);
        end
        check("single_done3", 64'(done[3]), 64'd1);
        check("single_busy", 64'(busy), 64'd0);

        // Round-robin over 0, 5, 31; every other FIFO loaded with zero.
        do_reset();
        gq.delete();
        for (int k = 0; k < N; k++) pop[k] = 32'd0;
        pop[0]  = 32'd3;
        pop[5]  = 32'd3;
        pop[31] = 32'd3;
        need    = '1;
        tick();
        check("rr_not_all_done", 64'(all_done), 64'd0);
        for (int c = 0; c < 22; c++) tick();
        check("rr_grants", 64'(gq.size()), 64'd9);
        if (gq.size() == 9) begin
            for (int i = 0; i < 9; i++) begin
                int e;
                e = (i % 3 == 0) ? 0 : ((i % 3 == 1) ? 5 : 31);
                check($sformatf("rr_id%0d", i), 64'(gq[i]), 64'(e));
            end
        end
        check("rr_all_done", 64'(all_done), 64'd1);

        // Backpressure on 7, then 8 not ready during arbitration.
        do_reset();
        gq.delete();
        gnt     = 1'b0;
        need[7] = 1'b1;
        pop[7]  = 32'd3;
        need[8] = 1'b1;
        pop[8]  = 32'd2;
        tick();
        tick();
        for (int c = 0; c < 5; c++) begin
            if (c == 2) ready[7] = 1'b0;
            tick();
            check("stall_req", 64'(req), 64'd1);
            check("stall_id", 64'(id), 64'd7);
        end
        ready[7] = 1'b1;
        ready[8] = 1'b0;
        gnt      = 1'b1;
        for (int c = 0; c < 8; c++) tick();
        cnt = 0;
        foreach (gq[i]) if (gq[i] == 8) cnt++;
        check("skip8_grants", 64'(cnt), 64'd0);
        check("bp_grants7", 64'(gq.size()), 64'd3);
        ready[8] = 1'b1;
        for (int c = 0; c < 6; c++) tick();
        check("bp_done8", 64'(done[8]), 64'd1);

        // Zero count, and wrap of the pointer from 31 to 2.
        do_reset();
        need[30] = 1'b1;
        pop[30]  = 32'd1;
        for (int c = 0; c < 4; c++) tick();
        need[31] = 1'b1;
        pop[31]  = 32'd0;
        tick();
        check("zero_done31", 64'(done[31]), 64'd1);
        check("zero_no_req", 64'(req), 64'd0);
        ready    = 32'h0000_0004;
        need[2]  = 1'b1;
        pop[2]   = 32'd1;
        need[5]  = 1'b1;
        pop[5]   = 32'd1;
        tick();
        tick();
        check("wrap_req", 64'(req), 64'd1);
        check("wrap_id", 64'(id), 64'd2);
        ready = '1;
        for (int c = 0; c < 6; c++) tick();

        // Reload of the in-flight FIFO on the grant cycle.
        do_reset();
        gq.delete();
        gnt     = 1'b0;
        need[4] = 1'b1;
        pop[4]  = 32'd2;
        tick();
        tick();
        check("coll_req", 64'(req), 64'd1);
        gnt     = 1'b1;
        need[4] = 1'b1;
        pop[4]  = 32'd9;
        tick();
        check("coll_done4", 64'(done[4]), 64'd0);
        check("coll_busy", 64'(busy), 64'd1);
        gq.delete();
        for (int c = 0; c < 25; c++) tick();
        check("coll_grants", 64'(gq.size()), 64'd9);
        check("coll_done_end", 64'(done[4]), 64'd1);

        // Random traffic against the model.
        for (int c = 0; c < 600; c++) begin
            rst = ($urandom_range(0, 149) == 0);
            for (int k = 0; k < N; k++) begin
                need[k] = ($urandom_range(0, 24) == 0);
                pop[k]  = 32'($urandom_range(0, 3));
            end
            ready = $urandom;
            gnt   = ($urandom_range(0, 2) != 0);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
